// File: rtl/mem_access_pkg.sv
// Shared types, default geometry and the address range check for the
// load/store bus initiator in front of the synchronous word memory.
package mem_access_pkg;

  localparam int AW_DEF        = 16;
  localparam int DW_DEF        = 16;
  localparam int MEM_DEPTH_DEF = 1024;
  localparam int LEN_W_DEF     = 4;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    WRITE,
    WACK,
    READ,
    DRAIN
  } state_e;

  // last_addr is the highest word a request would touch, already widened so
  // that a carry out of the address width shows up as a large value.
  function automatic logic range_err(input logic [31:0] last_addr,
                                     input logic [31:0] depth);
    return (last_addr > (depth - 32'd1));
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Bus initiator: single-beat writes and incrementing burst reads from the
// load/store unit onto a 1-cycle-latency synchronous word memory.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  input  logic [LEN_W-1:0] req_len,
  output logic             rsp_valid,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_last,
  output logic             rsp_err,
  output logic [AW-1:0]    mem_address,
  output logic [DW-1:0]    mem_data_in,
  output logic             mem_write_enable,
  input  logic [DW-1:0]    mem_data_out
);

  state_e             state_q, state_d;
  logic [AW-1:0]      mem_address_q, mem_address_d;
  logic [DW-1:0]      mem_data_in_q, mem_data_in_d;
  logic               mem_we_q, mem_we_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_last_q, rsp_last_d;
  logic               rsp_err_q, rsp_err_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issue_cnt_q, issue_cnt_d;

  // One extra bit so a 16-bit wrap of addr+len is caught as out of range.
  logic [AW:0] end_addr;
  logic        req_err;

  assign end_addr = req_write ? {1'b0, req_addr}
                              : ({1'b0, req_addr} + (AW+1)'(req_len));
  assign req_err  = range_err(32'(end_addr), 32'(MEM_DEPTH));

  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_we_d      = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_last_d    = 1'b0;
    rsp_err_d     = 1'b0;
    len_d         = len_q;
    issue_cnt_d   = issue_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          len_d       = req_len;
          issue_cnt_d = '0;
          if (req_err) begin
            state_d     = ERR;
            rsp_valid_d = 1'b1;
            rsp_last_d  = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_write) begin
            state_d       = WRITE;
            mem_address_d = req_addr;
            mem_data_in_d = req_wdata;
            mem_we_d      = 1'b1;
          end else begin
            state_d       = READ;
            mem_address_d = req_addr;
          end
        end
      end
      ERR:   state_d = IDLE;
      WRITE: begin
        state_d     = WACK;
        rsp_valid_d = 1'b1;
        rsp_last_d  = 1'b1;
      end
      WACK:  state_d = IDLE;
      READ: begin
        // The address on the bus this cycle returns data next cycle as a beat.
        rsp_valid_d = 1'b1;
        if (issue_cnt_q == len_q) begin
          state_d    = DRAIN;
          rsp_last_d = 1'b1;
        end else begin
          issue_cnt_d   = issue_cnt_q + LEN_W'(1);
          mem_address_d = mem_address_q + AW'(1);
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_last_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
      len_q         <= '0;
      issue_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_we_q      <= mem_we_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_last_q    <= rsp_last_d;
      rsp_err_q     <= rsp_err_d;
      len_q         <= len_d;
      issue_cnt_q   <= issue_cnt_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign rsp_valid        = rsp_valid_q;
  assign rsp_last         = rsp_last_q;
  assign rsp_err          = rsp_err_q;
  assign mem_address      = mem_address_q;
  assign mem_data_in      = mem_data_in_q;
  assign mem_write_enable = mem_we_q;
  assign rsp_data = (rsp_valid_q && !rsp_err_q && (state_q == READ || state_q == DRAIN))
                    ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 1024x16 registered-read memory
// model; expected read data comes from a bench-maintained shadow array.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [3:0]  req_len;
  logic        rsp_valid, rsp_last, rsp_err;
  logic [15:0] rsp_data;
  logic [15:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_write_enable;

  logic        preload_en;
  logic [9:0]  preload_addr;
  logic [15:0] preload_data;

  logic [15:0] mem_arr [0:1023];
  logic [15:0] model   [0:1023];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int beat_seen = 0;
  int we_seen   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_len          (req_len),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_last         (rsp_last),
    .rsp_err          (rsp_err),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable),
    .mem_data_out     (mem_data_out)
  );

  always @(posedge clk) begin
    if (preload_en)
      mem_arr[preload_addr] <= preload_data;
    else if (mem_write_enable)
      mem_arr[mem_address[9:0]] <= mem_data_in;
    mem_data_out <= mem_arr[mem_address[9:0]];
  end

  always @(posedge clk) begin
    if (rsp_valid) beat_seen++;
    if (mem_write_enable) we_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [15:0] init_word(input int i);
    if (i == 0) return 16'hA5A5;
    if (i == 1) return 16'h3C3C;
    if (i == 2) return 16'hF0F0;
    return 16'(16'h4000 + i * 5);
  endfunction

  // Present a request in one cycle; returns at the negedge of cycle 1 with
  // the request fields scrambled to prove they were latched.
  task automatic send(input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [3:0] len);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_len = len;
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL accept_ready: req_ready=%b required 1", req_ready);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_addr = 16'hDEAD; req_wdata = 16'hBEEF; req_len = 4'hF;
    $display("txn %s addr=%h wdata=%h len=%0d", wr ? "WR" : "RD", addr, wdata, len);
  endtask

  // Starts at cycle 1 of an accepted in-range read.
  task automatic expect_read(input logic [15:0] addr, input logic [3:0] len, input string tag);
    chk_cnt++;
    if (mem_address !== addr || rsp_valid !== 1'b0 || req_ready !== 1'b0 || mem_write_enable !== 1'b0)
      $display("FAIL %s_c1: addr=%h valid=%b ready=%b we=%b required addr=%h valid=0 ready=0 we=0",
               tag, mem_address, rsp_valid, req_ready, mem_write_enable, addr);
    else pass_cnt++;
    for (int k = 2; k <= int'(len) + 2; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== model[int'(addr) + k - 2] ||
          rsp_last !== (k == int'(len) + 2))
        $display("FAIL %s_beat%0d: valid=%b err=%b data=%h last=%b required 1 0 %h %b",
                 tag, k, rsp_valid, rsp_err, rsp_data, rsp_last,
                 model[int'(addr) + k - 2], (k == int'(len) + 2));
      else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL %s_done: ready=%b valid=%b required ready=1 valid=0", tag, req_ready, rsp_valid);
    else pass_cnt++;
  endtask

  // Starts at cycle 1 of a rejected request.
  task automatic expect_err(input string tag);
    chk_cnt++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_last !== 1'b1 || rsp_data !== 16'h0 ||
        mem_write_enable !== 1'b0)
      $display("FAIL %s_err: valid=%b err=%b last=%b data=%h we=%b required 1 1 1 0000 0",
               tag, rsp_valid, rsp_err, rsp_last, rsp_data, mem_write_enable);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL %s_ready: ready=%b valid=%b required ready=1 valid=0", tag, req_ready, rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
    preload_en = 1'b0; preload_addr = '0; preload_data = '0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      preload_en = 1'b1; preload_addr = 10'(i); preload_data = init_word(i);
      model[i] = init_word(i);
    end
    @(negedge clk);
    preload_en = 1'b0;
    chk_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_data !== 16'h0 || mem_address !== 16'h0 || mem_data_in !== 16'h0 || mem_write_enable !== 1'b0)
      $display("FAIL reset_state: ready=%b valid=%b last=%b err=%b data=%h addr=%h din=%h we=%b required 1 0 0 0 0000 0000 0000 0",
               req_ready, rsp_valid, rsp_last, rsp_err, rsp_data, mem_address, mem_data_in, mem_write_enable);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL reset_release: ready=%b valid=%b required ready=1 valid=0", req_ready, rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_read_basic();
    send(1'b0, 16'd0, 16'h0, 4'd2);
    expect_read(16'd0, 4'd2, "rd_a0_l2");
  endtask

  task automatic test_write();
    send(1'b1, 16'd5, 16'h1234, 4'd0);
    chk_cnt++;
    if (mem_write_enable !== 1'b1 || mem_address !== 16'd5 || mem_data_in !== 16'h1234 || rsp_valid !== 1'b0)
      $display("FAIL wr_c1: we=%b addr=%h din=%h valid=%b required 1 0005 1234 0",
               mem_write_enable, mem_address, mem_data_in, rsp_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (mem_write_enable !== 1'b0 || rsp_valid !== 1'b1 || rsp_last !== 1'b1 || rsp_err !== 1'b0 ||
        rsp_data !== 16'h0)
      $display("FAIL wr_ack: we=%b valid=%b last=%b err=%b data=%h required 0 1 1 0 0000",
               mem_write_enable, rsp_valid, rsp_last, rsp_err, rsp_data);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL wr_done: ready=%b valid=%b required ready=1 valid=0", req_ready, rsp_valid);
    else pass_cnt++;
    model[5] = 16'h1234;
    send(1'b0, 16'd5, 16'h0, 4'd0);
    expect_read(16'd5, 4'd0, "rd_back5");
  endtask

  task automatic test_range();
    int we0;
    int beats0;
    we0 = we_seen;
    send(1'b1, 16'd1024, 16'hCAFE, 4'd0);
    expect_err("wr_1024");
    send(1'b0, 16'd1020, 16'h0, 4'd4);
    expect_err("rd_1020_l4");
    send(1'b0, 16'd1019, 16'h0, 4'd4);
    expect_read(16'd1019, 4'd4, "rd_1019_l4");
    beats0 = beat_seen;
    send(1'b0, 16'hFFFF, 16'h0, 4'd1);
    expect_err("rd_ffff_l1");
    @(negedge clk);
    chk_cnt++;
    if (we_seen !== we0 || beat_seen !== beats0 + 1)
      $display("FAIL range_side_effects: we_pulses=%0d beats=%0d required %0d %0d",
               we_seen, beat_seen, we0, beats0 + 1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    int beats0;
    send(1'b0, 16'd0, 16'h0, 4'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    beats0 = beat_seen;
    chk_cnt++;
    if (rsp_valid !== 1'b0 || mem_write_enable !== 1'b0 || req_ready !== 1'b1 || mem_address !== 16'h0)
      $display("FAIL rst_mid: valid=%b we=%b ready=%b addr=%h required 0 0 1 0000",
               rsp_valid, mem_write_enable, req_ready, mem_address);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk_cnt++;
    if (beat_seen !== beats0 || req_ready !== 1'b1)
      $display("FAIL rst_no_stray: beats=%0d ready=%b required %0d 1", beat_seen, req_ready, beats0);
    else pass_cnt++;
    send(1'b0, 16'd2, 16'h0, 4'd0);
    expect_read(16'd2, 4'd0, "rd_after_rst");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd0; req_len = 4'd1;
    @(negedge clk);
    req_addr = 16'd2; req_len = 4'd0;
    $display("txn RD addr=0000 len=1 then held RD addr=0002 len=0");
    chk_cnt++;
    if (req_ready !== 1'b0 || mem_address !== 16'd0)
      $display("FAIL b2b_c1: ready=%b addr=%h required 0 0000", req_ready, mem_address);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5A5 || rsp_last !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL b2b_beat0: valid=%b data=%h last=%b ready=%b required 1 a5a5 0 0",
               rsp_valid, rsp_data, rsp_last, req_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h3C3C || rsp_last !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL b2b_beat1: valid=%b data=%h last=%b ready=%b required 1 3c3c 1 0",
               rsp_valid, rsp_data, rsp_last, req_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL b2b_idle: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b0;
    chk_cnt++;
    if (req_ready !== 1'b0 || mem_address !== 16'd2 || rsp_valid !== 1'b0)
      $display("FAIL b2b_second_c1: ready=%b addr=%h valid=%b required 0 0002 0",
               req_ready, mem_address, rsp_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hF0F0 || rsp_last !== 1'b1)
      $display("FAIL b2b_second_beat: valid=%b data=%h last=%b required 1 f0f0 1",
               rsp_valid, rsp_data, rsp_last);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL b2b_done: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write();
    test_range();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Bus initiator between the 6502 core's load/store unit and the 1024x16 synchronous word memory.
- Accepts single-beat write requests and incrementing burst read requests through a valid/ready port.
- Drives the memory's address, data_in and write_enable pins, and returns read data with the memory's one-cycle read latency.
- Range-checks every request against MEM_DEPTH, so out-of-range addresses never reach the memory array.

Parameters:
- AW, 16, address width (request and memory side).
- DW, 16, data width.
- MEM_DEPTH, 1024, number of valid words; legal addresses are 0..MEM_DEPTH-1.
- LEN_W, 4, burst length field width; beats = req_len+1, up to 16.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  start word address.
- req_wdata  in  DW  write data (writes only).
- req_len  in  LEN_W  beats-1 (reads only; ignored for writes).
- rsp_valid  out  1  response beat valid; there is no backpressure, so the core must sample it every cycle.
- rsp_data  out  DW  read data; 0 on a write ack or an error.
- rsp_last  out  1  final beat of the request.
- rsp_err  out  1  request rejected (out of range).
- mem_address  out  AW  to memory address.
- mem_data_in  out  DW  to memory data_in.
- mem_write_enable  out  1  to memory write_enable.
- mem_data_out  in  DW  from memory; registered in memory, valid one cycle after the address.

Behaviour:
- Reset (async) values:
  - state = IDLE, req_ready = 1.
  - rsp_valid, rsp_last, rsp_err = 0; rsp_data = 0.
  - mem_address, mem_data_in = 0; mem_write_enable = 0.
  - beat and issue counters = 0.
- Reset mid-burst or mid-write aborts immediately: mem_write_enable drops with reset, and no further rsp beats are issued.
- All mem_* outputs and rsp_valid/rsp_last/rsp_err are registered. rsp_data is muxed: mem_data_out during read beats, otherwise 0.
- Acceptance: cycle 0, when req_valid && req_ready are sampled at the rising edge. The request fields are latched at that edge.
- Range check at acceptance:
  - Write: error if req_addr > MEM_DEPTH-1.
  - Read: error if req_addr + req_len > MEM_DEPTH-1. The sum is computed at AW+1 bits, so 16-bit wrap counts as out of range.
- States:
  - IDLE
    - req_ready = 1, mem_write_enable = 0.
    - On accept with error: go to ERR.
    - On accept with a write: go to WRITE.
    - On accept with a read: go to READ.
  - ERR, 1 cycle (cycle 1)
    - rsp_valid = 1, rsp_err = 1, rsp_last = 1, rsp_data = 0.
    - No memory access; mem_write_enable stays 0.
    - Next state IDLE (ready again in cycle 2).
  - WRITE, 1 cycle (cycle 1)
    - mem_address = addr, mem_data_in = wdata, mem_write_enable = 1.
    - Next state WACK.
  - WACK, 1 cycle (cycle 2)
    - mem_write_enable = 0.
    - rsp_valid = 1, rsp_last = 1, rsp_err = 0, rsp_data = 0.
    - Next state IDLE (ready in cycle 3).
  - READ, cycles 1..len+1
    - In cycle k, mem_address = addr+(k-1), mem_write_enable = 0.
    - From cycle 2, each cycle also emits a rsp beat for the previous address: rsp_data = mem_data_out.
    - After the address addr+len has been issued, go to DRAIN.
  - DRAIN, cycle len+2
    - Emits the final beat with rsp_last = 1.
    - Next state IDLE (ready in cycle len+3).
- Read latency: the first beat is at cycle 2. Beats are back-to-back, one per cycle, with exactly len+1 beats. rsp_last is high only on the final beat.
- req_valid outside IDLE is ignored (req_ready = 0); a request held across busy cycles is accepted on its first IDLE cycle.
- The latched request is immune to req_* changes after acceptance.

Decomposition:
- Package mem_access_pkg holds:
  - state enum: IDLE, ERR, WRITE, WACK, READ, DRAIN;
  - AW, DW, MEM_DEPTH, LEN_W defaults;
  - a range-check function.
- Single module; no sub-module is needed. The beat counter and address incrementer are inline.

Test Plan:
- Bench memory model preloaded with mem[0]=A5A5, mem[1]=3C3C, mem[2]=F0F0.
- Read addr 0, len 2 -> rsp beats in cycles 2, 3, 4 with data A5A5, 3C3C, F0F0; rsp_last only on cycle 4; req_ready back to 1 in cycle 5.
- Write addr 5, data 1234 -> mem_write_enable=1 only in cycle 1 with mem_address=5; ack in cycle 2 (data 0, last=1, err=0); a following read of addr 5 returns 1234.
- Write addr 1024 -> rsp_err=1, last=1 in cycle 1; mem_write_enable never asserted; ready in cycle 2.
- Read addr 1020, len 4 (end address 1024) -> single error beat; read addr 1019, len 4 -> 5 valid beats, no error.
- Boundary: read addr FFFF, len 1 -> error, no wrap-around access.
- Assert reset in cycle 3 of a len=7 read -> rsp_valid=0 immediately, req_ready=1 after release, no stray beats; next read of addr 2 returns F0F0.
- req_valid held high during a burst -> second request accepted only on the IDLE cycle after DRAIN; no beat overlap.
